sl_report_sched: RTL and testbench
==================================

# sl_report_sched

Round-robin scheduler that shares the single upstream FIFO write port between NUM_CH SL transceiver channels. It captures per-channel change events (config, received data+status), snapshots the values, and serializes them as 34-bit tagged words. A channel-tag word is inserted whenever the reporting channel differs from the last one reported. It sits between the TX/RX channel instances and the write side of the host-bound FIFO, alongside the FIFO-to-TX/RX bridge.

## Interface
- NUM_CH, 4, number of reporting channels (2..16)
- CH_W, $clog2(NUM_CH), channel index width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ev_config  in  NUM_CH  per-channel pulse: config changed
- ev_data  in  NUM_CH  per-channel pulse: rx data + status valid
- cfg_in  in  NUM_CH*16  per-channel config, slice [16*i+:16]
- data_in  in  NUM_CH*32  per-channel rx data, slice [32*i+:32]
- status_in  in  NUM_CH*16  per-channel rx status, slice [16*i+:16]
- fifo_write_full  in  1  upstream FIFO full
- fifo_write_data  out  34  tagged word: [33:32] tag, [31:0] payload
- fifo_write_inc  out  1  write strobe, one word per asserted cycle
- overrun  out  NUM_CH  sticky: an event overwrote an unserviced snapshot
- busy  out  1  scheduler not in IDLE

## Operation
- Tags: 0 = config (payload {16'h0,cfg}), 1 = data (32-bit), 2 = status ({16'h0,status}), 3 = channel ({zeros,ch}).
- Per channel: pend_cfg, pend_data bits, plus snapshots cfg_s, data_s, stat_s. On an event edge, the pending bit is set and the snapshot loads from the inputs in that cycle.
- If an event hits an already-pending bit, the snapshot is overwritten and overrun[i] is set. overrun clears only on rst.
- If an event coincides with the grant that clears the same pending bit, the new event wins: the bit stays set, the new snapshot is stored, and no overrun is flagged. The granted sequence uses the pre-event values.
- FSM states: IDLE, SEND_CH, SEND_CFG, SEND_DATA, SEND_STAT.
- IDLE: if any channel is pending, the sub-arbiter grants the first pending channel searching from last_grant+1 with wrap-around.
  - On the grant edge, the block copies the channel's pending flags and snapshots into work registers, clears those pending bits, and updates last_grant.
  - Next state is the first applicable in order: SEND_CH (only if granted ch ≠ cur_ch or cur_ch invalid), then SEND_CFG, then SEND_DATA.
- Sequence after the grant: CH → CFG (if cfg) → DATA → STAT (if data). STAT always immediately follows DATA.
- After the last accepted word, the FSM returns to IDLE. cur_ch is set to the granted channel once the CH word is accepted.
- Send states: fifo_write_data is driven from the work registers. fifo_write_inc = !fifo_write_full. The state advances only on a cycle with fifo_write_inc = 1.
- Full: the word is held stable and the FSM stalls indefinitely. No word is ever dropped or duplicated.

## Timing
- Reset values: state IDLE, all pending = 0, snapshots = 0, overrun = 0, last_grant = NUM_CH-1 (channel 0 has first priority), cur_ch invalid, fifo_write_inc = 0, fifo_write_data = 0, busy = 0.
- Event sampled at edge E → grant at edge E+1 → first word written at edge E+2 (if not full).
- Each word takes 1 cycle when not full. There is one IDLE bubble cycle between sequences.
- Worst case per grant: 4 words (CH, CFG, DATA, STAT).
- rst mid-sequence: unaccepted words are lost, and all pending events and snapshots are discarded.
- fifo_write_data is combinationally valid only while fifo_write_inc = 1. It reads 0 in IDLE.

## Structure
- Package sl_fifo_pkg holds:
  - WORD_W = 34, TAG_W = 2
  - TAG_CONFIG = 0, TAG_DATA = 1, TAG_STATUS = 2, TAG_CHANNEL = 3
  - state enum for this FSM
  - CFG_W = 16, DATA_W = 32, STAT_W = 16
- One sub-module, sl_rr_arbiter (parameter N): inputs req[N] and last[CH_W]; outputs gnt_valid and gnt_idx. It is purely combinational, with rotate-priority from last+1.

## Test plan
- Reset, then ev_config[0] with cfg_in[0] = 16'h0022 → words 34'h3_00000000 then 34'h0_00000022 on consecutive cycles starting at E+2, then busy = 0.
- ev_data[1], data_in[1] = 32'd456791, status_in[1] = 16'd76 → 34'h3_00000001, 34'h1_0006F857, 34'h2_0000004C. A repeat ev_data[1] afterwards emits no CH word.
- Same-cycle ev_config on channels 0, 2, 3 with last_grant = 1 → service order 2, 3, 0, each preceded by its CH word.
- fifo_write_full held high for 5 cycles mid-sequence → fifo_write_inc = 0, data held stable. After release, the remaining words are emitted exactly once.
- Two ev_config[2] pulses (16'h0011 then 16'h0099) before grant → only 16'h0099 is reported and overrun[2] = 1. An event on the exact grant cycle → reported in the next sequence, with overrun = 0.
- rst asserted during SEND_DATA → next cycle fifo_write_inc = 0, busy = 0, and no stale words appear after reset release.

Source files
------------

// File: rtl/sl_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sl_fifo_pkg
// Shared definitions for the SL report scheduler: word layout, tag codes,
// field widths and the scheduler FSM state type.
// ----------------------------------------------------------------------------
package sl_fifo_pkg;

    localparam int WORD_W = 34;
    localparam int TAG_W  = 2;
    localparam int CFG_W  = 16;
    localparam int DATA_W = 32;
    localparam int STAT_W = 16;

    localparam logic [TAG_W-1:0] TAG_CONFIG  = 2'd0;
    localparam logic [TAG_W-1:0] TAG_DATA    = 2'd1;
    localparam logic [TAG_W-1:0] TAG_STATUS  = 2'd2;
    localparam logic [TAG_W-1:0] TAG_CHANNEL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CH,
        ST_SEND_CFG,
        ST_SEND_DATA,
        ST_SEND_STAT
    } sched_state_e;

    // Assemble a tagged FIFO word.
    function automatic logic [WORD_W-1:0] make_word(input logic [TAG_W-1:0]  tag,
                                                    input logic [DATA_W-1:0] payload);
        return {tag, payload};
    endfunction

endpackage

// File: rtl/sl_report_sched_if.sv
// ----------------------------------------------------------------------------
// sl_report_sched_if
// Write side of the host-bound FIFO.
//   fifo_write_full  : FIFO cannot accept a word this cycle
//   fifo_write_data  : 34-bit tagged word
//   fifo_write_inc   : write strobe
// Handshake: the master presents a word on fifo_write_data and asserts
// fifo_write_inc only when fifo_write_full is low; a word transfers on every
// rising edge where fifo_write_inc = 1. While full is high the master holds
// the word stable and keeps fifo_write_inc low.
// ----------------------------------------------------------------------------
interface sl_report_sched_if;
    import sl_fifo_pkg::*;

    logic              fifo_write_full;
    logic [WORD_W-1:0] fifo_write_data;
    logic              fifo_write_inc;

    modport master (input fifo_write_full, output fifo_write_data, output fifo_write_inc);
    modport slave  (output fifo_write_full, input fifo_write_data, input fifo_write_inc);

endinterface

// File: rtl/sl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// sl_rr_arbiter
// Combinational rotate-priority arbiter: picks the first asserted request
// searching from last+1 with wrap-around.
//   req       : request vector
//   last      : index granted most recently
//   gnt_valid : some request is asserted
//   gnt_idx   : winning index
// ----------------------------------------------------------------------------
module sl_rr_arbiter #(
    parameter int N    = 4,
    parameter int CH_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] last,
    output logic            gnt_valid,
    output logic [CH_W-1:0] gnt_idx
);

    always_comb begin
        logic [CH_W-1:0] w_idx;
        w_idx     = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Walk from the farthest candidate to the nearest so the nearest
        // asserted request is the last one written and wins.
        for (int k = N; k >= 1; k--) begin
            w_idx = CH_W'((int'(last) + k) % N);
            if (req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/sl_report_sched.sv
// ----------------------------------------------------------------------------
// sl_report_sched
// Round-robin scheduler sharing the host FIFO write port between NUM_CH
// channels. Events snapshot channel values; a grant serialises them as
// CH (when the channel changes) -> CFG -> DATA -> STAT tagged words.
//   clk, rst         : clock, synchronous active-high reset
//   ev_config/ev_data: per-channel event pulses
//   cfg_in/data_in/status_in : per-channel values, sampled on the event
//   fifo             : FIFO write port (master side)
//   overrun          : sticky, an event overwrote an unserviced snapshot
//   busy             : FSM not idle
//   o_dbg_state      : current FSM state
// ----------------------------------------------------------------------------
module sl_report_sched
    import sl_fifo_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ev_config,
    input  logic [NUM_CH-1:0]        ev_data,
    input  logic [NUM_CH*CFG_W-1:0]  cfg_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH*STAT_W-1:0] status_in,
    sl_report_sched_if.master        fifo,
    output logic [NUM_CH-1:0]        overrun,
    output logic                     busy,
    output sched_state_e             o_dbg_state
);

    sched_state_e      r_state, w_state_nxt;
    logic [NUM_CH-1:0] r_pend_cfg, r_pend_data, r_overrun;
    logic [CFG_W-1:0]  r_cfg_s  [NUM_CH];
    logic [DATA_W-1:0] r_data_s [NUM_CH];
    logic [STAT_W-1:0] r_stat_s [NUM_CH];
    logic [CH_W-1:0]   r_last_grant, r_cur_ch, r_w_ch;
    logic              r_cur_valid;
    logic              r_w_cfg_pend, r_w_data_pend;
    logic [CFG_W-1:0]  r_w_cfg;
    logic [DATA_W-1:0] r_w_data;
    logic [STAT_W-1:0] r_w_stat;

    logic              w_gnt_valid, w_grant, w_inc;
    logic [CH_W-1:0]   w_gnt_idx;
    logic [NUM_CH-1:0] w_clr;
    logic [WORD_W-1:0] w_word;

    sl_rr_arbiter #(.N(NUM_CH), .CH_W(CH_W)) u_arb (
        .req       (r_pend_cfg | r_pend_data),
        .last      (r_last_grant),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_grant = (r_state == ST_IDLE) && w_gnt_valid;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_clr[i] = w_grant && (w_gnt_idx == CH_W'(i));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_word      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    if (!r_cur_valid || (w_gnt_idx != r_cur_ch)) w_state_nxt = ST_SEND_CH;
                    else if (r_pend_cfg[w_gnt_idx])             w_state_nxt = ST_SEND_CFG;
                    else                                        w_state_nxt = ST_SEND_DATA;
                end
            end
            ST_SEND_CH: begin
                w_inc  = !fifo.fifo_write_full;
                w_word = make_word(TAG_CHANNEL, DATA_W'(r_w_ch));
                if (w_inc) begin
                    if (r_w_cfg_pend)       w_state_nxt = ST_SEND_CFG;
                    else if (r_w_data_pend) w_state_nxt = ST_SEND_DATA;
                    else                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND_CFG: begin
                w_inc  = !fifo.fifo_write_full;
                w_word = make_word(TAG_CONFIG, DATA_W'(r_w_cfg));
                if (w_inc) w_state_nxt = r_w_data_pend ? ST_SEND_DATA : ST_IDLE;
            end
            ST_SEND_DATA: begin
                w_inc  = !fifo.fifo_write_full;
                w_word = make_word(TAG_DATA, r_w_data);
                if (w_inc) w_state_nxt = ST_SEND_STAT;
            end
            ST_SEND_STAT: begin
                w_inc  = !fifo.fifo_write_full;
                w_word = make_word(TAG_STATUS, DATA_W'(r_w_stat));
                if (w_inc) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pend_cfg    <= '0;
            r_pend_data   <= '0;
            r_overrun     <= '0;
            r_last_grant  <= CH_W'(NUM_CH - 1);
            r_cur_ch      <= '0;
            r_cur_valid   <= 1'b0;
            r_w_ch        <= '0;
            r_w_cfg_pend  <= 1'b0;
            r_w_data_pend <= 1'b0;
            r_w_cfg       <= '0;
            r_w_data      <= '0;
            r_w_stat      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cfg_s[i]  <= '0;
                r_data_s[i] <= '0;
                r_stat_s[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            // Work registers take the pre-event snapshot of the granted channel.
            if (w_grant) begin
                r_w_ch        <= w_gnt_idx;
                r_w_cfg_pend  <= r_pend_cfg[w_gnt_idx];
                r_w_data_pend <= r_pend_data[w_gnt_idx];
                r_w_cfg       <= r_cfg_s[w_gnt_idx];
                r_w_data      <= r_data_s[w_gnt_idx];
                r_w_stat      <= r_stat_s[w_gnt_idx];
                r_last_grant  <= w_gnt_idx;
            end
            if ((r_state == ST_SEND_CH) && w_inc) begin
                r_cur_ch    <= r_w_ch;
                r_cur_valid <= 1'b1;
            end
            // A new event beats a same-cycle grant clear; overrun only when
            // the snapshot being replaced was never taken by a grant.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ev_config[i]) begin
                    r_pend_cfg[i] <= 1'b1;
                    r_cfg_s[i]    <= cfg_in[CFG_W*i +: CFG_W];
                    if (r_pend_cfg[i] && !w_clr[i]) r_overrun[i] <= 1'b1;
                end else if (w_clr[i]) begin
                    r_pend_cfg[i] <= 1'b0;
                end
                if (ev_data[i]) begin
                    r_pend_data[i] <= 1'b1;
                    r_data_s[i]    <= data_in[DATA_W*i +: DATA_W];
                    r_stat_s[i]    <= status_in[STAT_W*i +: STAT_W];
                    if (r_pend_data[i] && !w_clr[i]) r_overrun[i] <= 1'b1;
                end else if (w_clr[i]) begin
                    r_pend_data[i] <= 1'b0;
                end
            end
        end
    end

    assign fifo.fifo_write_inc  = w_inc;
    assign fifo.fifo_write_data = w_word;
    assign overrun              = r_overrun;
    assign busy                 = (r_state != ST_IDLE);
    assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_sl_report_sched.sv
module tb_sl_report_sched;
  import sl_fifo_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]    ev_config = '0;
  logic [NUM_CH-1:0]    ev_data   = '0;
  logic [NUM_CH*16-1:0] cfg_in    = '0;
  logic [NUM_CH*32-1:0] data_in   = '0;
  logic [NUM_CH*16-1:0] status_in = '0;
  logic [NUM_CH-1:0]    overrun;
  logic                 busy;
  sched_state_e         dbg_state;

  sl_report_sched_if fifo_if ();

  sl_report_sched #(.NUM_CH(NUM_CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ev_config   (ev_config),
    .ev_data     (ev_data),
    .cfg_in      (cfg_in),
    .data_in     (data_in),
    .status_in   (status_in),
    .fifo        (fifo_if.master),
    .overrun     (overrun),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- behavioural model ----------------
  // Words of the sequence being sent sit in m_seq; a sequence is built in
  // one go at the grant and drained one word per non-full cycle.
  logic [33:0]       m_seq[$];
  bit                m_pc[NUM_CH];
  bit                m_pd[NUM_CH];
  logic [15:0]       m_cfg[NUM_CH];
  logic [31:0]       m_dat[NUM_CH];
  logic [15:0]       m_st[NUM_CH];
  logic [NUM_CH-1:0] m_ovr;
  int                m_last;
  int                m_cur;

  always @(posedge clk) begin
    int g;
    int c;
    if (rst) begin
      m_seq.delete();
      for (int i = 0; i < NUM_CH; i++) begin
        m_pc[i] = 0; m_pd[i] = 0; m_cfg[i] = '0; m_dat[i] = '0; m_st[i] = '0;
      end
      m_ovr  = '0;
      m_last = NUM_CH - 1;
      m_cur  = -1;
    end else begin
      if (m_seq.size() > 0) begin
        if (!fifo_if.fifo_write_full) begin
          if (m_seq[0][33:32] == TAG_CHANNEL) m_cur = int'(m_seq[0][CH_W-1:0]);
          void'(m_seq.pop_front());
        end
      end else begin
        g = -1;
        for (int k = 1; k <= NUM_CH; k++) begin
          c = (m_last + k) % NUM_CH;
          if (g < 0 && (m_pc[c] || m_pd[c])) g = c;
        end
        if (g >= 0) begin
          if (g != m_cur) m_seq.push_back({TAG_CHANNEL, 32'(g)});
          if (m_pc[g]) m_seq.push_back({TAG_CONFIG, 16'h0, m_cfg[g]});
          if (m_pd[g]) begin
            m_seq.push_back({TAG_DATA, m_dat[g]});
            m_seq.push_back({TAG_STATUS, 16'h0, m_st[g]});
          end
          m_pc[g] = 0;
          m_pd[g] = 0;
          m_last  = g;
        end
      end
      // Events after the grant: a cleared bit cannot overrun.
      for (int i = 0; i < NUM_CH; i++) begin
        if (ev_config[i]) begin
          if (m_pc[i]) m_ovr[i] = 1'b1;
          m_pc[i] = 1; m_cfg[i] = cfg_in[16*i +: 16];
        end
        if (ev_data[i]) begin
          if (m_pd[i]) m_ovr[i] = 1'b1;
          m_pd[i] = 1; m_dat[i] = data_in[32*i +: 32]; m_st[i] = status_in[16*i +: 16];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [33:0] log_q[$];

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic        e_busy;
    logic        e_inc;
    logic [33:0] e_data;
    e_busy = (m_seq.size() > 0);
    e_inc  = e_busy && !fifo_if.fifo_write_full;
    e_data = e_busy ? m_seq[0] : 34'h0;
    chk("inc",     fifo_if.fifo_write_inc,  e_inc);
    chk("data",    fifo_if.fifo_write_data, e_data);
    chk("busy",    busy,                    e_busy);
    chk("overrun", overrun,                 m_ovr);
    if (fifo_if.fifo_write_inc) log_q.push_back(fifo_if.fifo_write_data);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge; the compare runs 1 time unit
  // later, still well before the next rising edge.
  task automatic cyc();
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_cfg(input int ch, input logic [15:0] v);
    cfg_in[16*ch +: 16] = v;
    ev_config[ch] = 1'b1;
    cyc();
    ev_config = '0;
  endtask

  task automatic pulse_data(input int ch, input logic [31:0] d, input logic [15:0] s);
    data_in[32*ch +: 32]   = d;
    status_in[16*ch +: 16] = s;
    ev_data[ch] = 1'b1;
    cyc();
    ev_data = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit pend_any;
    fifo_if.fifo_write_full = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    #1;
    chk("rst_inc",  fifo_if.fifo_write_inc, 34'h0);
    chk("rst_data", fifo_if.fifo_write_data, 34'h0);
    chk("rst_busy", busy, 34'h0);
    chk("rst_ovr",  overrun, 34'h0);
    @(negedge clk);

    // Single config event on channel 0; first word appears after the grant.
    log_q.delete();
    pulse_cfg(0, 16'h0022);
    #1 chk("t1_lat_inc0", fifo_if.fifo_write_inc, 34'h0);
    cyc();
    #1 chk("t1_lat_inc1", fifo_if.fifo_write_inc, 34'h1);
    chk("t1_lat_word", fifo_if.fifo_write_data, 34'h3_00000000);
    run(6);
    chk("t1_count", 34'(log_q.size()), 34'd2);
    chk("t1_w0", log_q[0], 34'h3_00000000);
    chk("t1_w1", log_q[1], 34'h0_00000022);
    chk("t1_busy", busy, 34'h0);

    // Data event on channel 1, then a repeat with no CH word.
    log_q.delete();
    pulse_data(1, 32'd456791, 16'd76);
    run(8);
    chk("t2_count", 34'(log_q.size()), 34'd3);
    chk("t2_w0", log_q[0], 34'h3_00000001);
    chk("t2_w1", log_q[1], 34'h1_0006F857);
    chk("t2_w2", log_q[2], 34'h2_0000004C);
    log_q.delete();
    pulse_data(1, 32'h0000_0010, 16'h0020);
    run(8);
    chk("t2r_count", 34'(log_q.size()), 34'd2);
    chk("t2r_w0", log_q[0], 34'h1_00000010);

    // Simultaneous config events on 0, 2, 3 with last grant = 1.
    log_q.delete();
    cfg_in[16*0 +: 16] = 16'hA000;
    cfg_in[16*2 +: 16] = 16'hA002;
    cfg_in[16*3 +: 16] = 16'hA003;
    ev_config = 4'b1101;
    cyc();
    ev_config = '0;
    run(14);
    chk("t3_count", 34'(log_q.size()), 34'd6);
    chk("t3_ch_a", log_q[0], 34'h3_00000002);
    chk("t3_cf_a", log_q[1], 34'h0_0000A002);
    chk("t3_ch_b", log_q[2], 34'h3_00000003);
    chk("t3_ch_c", log_q[4], 34'h3_00000000);
    chk("t3_cf_c", log_q[5], 34'h0_0000A000);

    // Full for 5 cycles in the middle of a sequence.
    log_q.delete();
    pulse_data(3, 32'hDEADBEEF, 16'h1234);
    cyc();
    cyc();
    fifo_if.fifo_write_full = 1'b1;
    run(5);
    fifo_if.fifo_write_full = 1'b0;
    run(8);
    chk("t4_count", 34'(log_q.size()), 34'd3);
    chk("t4_w0", log_q[0], 34'h3_00000003);
    chk("t4_w1", log_q[1], 34'h1_DEADBEEF);
    chk("t4_w2", log_q[2], 34'h2_00001234);

    // Two config events on channel 2 while the scheduler is stalled.
    log_q.delete();
    fifo_if.fifo_write_full = 1'b1;
    pulse_data(1, 32'h0000_0001, 16'h0002);
    run(3);
    pulse_cfg(2, 16'h0011);
    pulse_cfg(2, 16'h0099);
    fifo_if.fifo_write_full = 1'b0;
    run(15);
    chk("t5_count", 34'(log_q.size()), 34'd5);
    chk("t5_cfg", log_q[4], 34'h0_00000099);
    chk("t5_ovr2", 34'(overrun[2]), 34'h1);

    // Event on the exact grant edge is kept for the next sequence.
    log_q.delete();
    pulse_cfg(0, 16'h0055);
    pulse_cfg(0, 16'h0066);
    run(10);
    chk("t6_count", 34'(log_q.size()), 34'd3);
    chk("t6_w1", log_q[1], 34'h0_00000055);
    chk("t6_w2", log_q[2], 34'h0_00000066);
    chk("t6_ovr0", 34'(overrun[0]), 34'h0);

    // Reset during SEND_DATA.
    pulse_data(2, 32'h1111_2222, 16'h3333);
    cyc();
    cyc();
    #1 chk("t7_busy_pre", busy, 34'h1);
    rst = 1'b1;
    cyc();
    #1 chk("t7_inc_rst", fifo_if.fifo_write_inc, 34'h0);
    chk("t7_busy_rst", busy, 34'h0);
    rst = 1'b0;
    log_q.delete();
    run(10);
    chk("t7_stale", 34'(log_q.size()), 34'd0);

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ev_config[i] = ($urandom_range(0, 11) == 0);
        ev_data[i]   = ($urandom_range(0, 11) == 0);
        cfg_in[16*i +: 16]    = 16'($urandom);
        data_in[32*i +: 32]   = $urandom;
        status_in[16*i +: 16] = 16'($urandom);
      end
      fifo_if.fifo_write_full = ($urandom_range(0, 3) == 0);
      cyc();
    end
    ev_config = '0;
    ev_data   = '0;
    fifo_if.fifo_write_full = 1'b0;
    for (int n = 0; n < 300; n++) begin
      pend_any = 0;
      for (int i = 0; i < NUM_CH; i++) pend_any |= (m_pc[i] | m_pd[i]);
      if (m_seq.size() == 0 && !pend_any) break;
      cyc();
    end
    run(2);
    chk("drain_busy", busy, 34'h0);
    chk("drain_model", 34'(m_seq.size()), 34'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
